// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg
//   Shared types and helpers for the scan multiplexer.
//   scan_state_t : controller state encoding (IDLE, DIRECT, SCAN)
//   idx_in_range : 1 when a requested channel index addresses a real channel
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } scan_state_t;

  function automatic logic idx_in_range(input int idx, input int num_inputs);
    return (idx >= 0) && (idx < num_inputs);
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter
//   Counts cycles spent on one channel while scanning.
//   clk    : system clock, rising edge
//   rst    : synchronous, active-high reset (count -> 0)
//   clear  : restart the dwell period (count -> 0)
//   enable : count this cycle
//   tc     : high while the count sits on its last value (DWELL-1); the
//            controller advances the channel when tc and enable coincide
module dwell_counter #(
  parameter int DWELL = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  // tc is not gated by enable so the controller can use it without
  // forming a combinational loop through its own enable decision.
  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_multiplexer.sv
// scan_multiplexer
//   Registered N-to-1 channel selector with latched selection, round-robin
//   scan mode with programmable dwell, and an output freeze.
//   clk      : system clock, rising edge
//   rst      : synchronous, active-high reset
//   data_in  : packed channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   sel_in   : requested channel, latched by sel_load
//   sel_load : one-cycle strobe latching sel_in
//   scan_en  : level, 1 = round-robin scan
//   hold     : level, freezes the whole block
//   y        : registered selected channel
//   y_valid  : y carries data from a selected channel
//   cur_sel  : currently latched channel index
//   sel_err  : one-cycle pulse on a load of an out-of-range index
//
//   state  | meaning
//   IDLE   | no channel selected yet, y held at 0
//   DIRECT | showing the latched channel
//   SCAN   | stepping through channels, DWELL cycles each
module scan_multiplexer
  import scan_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_INPUTS = 16,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS),
  parameter int DWELL      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
  input  logic [SEL_WIDTH-1:0]             sel_in,
  input  logic                             sel_load,
  input  logic                             scan_en,
  input  logic                             hold,
  output logic [DATA_WIDTH-1:0]            y,
  output logic                             y_valid,
  output logic [SEL_WIDTH-1:0]             cur_sel,
  output logic                             sel_err
);

  scan_state_t           state_q, state_d;
  logic [SEL_WIDTH-1:0]  cur_sel_d, sel_next;
  logic [DATA_WIDTH-1:0] y_d, chan_data;
  logic                  y_valid_d, sel_err_d;
  logic                  load_ok;
  logic                  dwell_clear, dwell_en, dwell_tc;

  assign load_ok   = idx_in_range(int'(sel_in), NUM_INPUTS);
  assign chan_data = data_in[int'(cur_sel) * DATA_WIDTH +: DATA_WIDTH];
  // Explicit wrap keeps a non-power-of-two channel count from reaching an
  // index that has no channel behind it.
  assign sel_next  = (cur_sel == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : cur_sel + 1'b1;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (dwell_clear),
    .enable (dwell_en),
    .tc     (dwell_tc)
  );

  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel;
    y_d         = y;
    y_valid_d   = y_valid;
    sel_err_d   = 1'b0;
    dwell_clear = 1'b0;
    dwell_en    = 1'b0;

    if (!hold) begin
      if (state_q != IDLE) begin
        y_d       = chan_data;
        y_valid_d = 1'b1;
      end

      if (sel_load) begin
        if (load_ok) begin
          cur_sel_d   = sel_in;
          dwell_clear = 1'b1;
          state_d     = scan_en ? SCAN : DIRECT;
        end else begin
          sel_err_d = 1'b1;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (scan_en) begin
              state_d     = SCAN;
              cur_sel_d   = '0;
              dwell_clear = 1'b1;
            end
          end
          DIRECT: begin
            if (scan_en) begin
              state_d     = SCAN;
              dwell_clear = 1'b1;
            end
          end
          SCAN: begin
            if (!scan_en) begin
              state_d = DIRECT;
            end else begin
              dwell_en = 1'b1;
              if (dwell_tc) begin
                cur_sel_d = sel_next;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_sel <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_sel <= cur_sel_d;
      y       <= y_d;
      y_valid <= y_valid_d;
      sel_err <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_scan_multiplexer.sv
// tb_scan_multiplexer
//   Scoreboard bench for scan_multiplexer (10 channels, 4-bit data, dwell 3).
//   The driver applies inputs, steps a behavioural model and queues the
//   expected outputs; a monitor pops and compares after every edge.
module tb_scan_multiplexer;

  localparam int DW  = 4;
  localparam int N   = 10;
  localparam int SW  = 4;
  localparam int DWL = 3;

  logic            clk = 1'b0;
  logic            rst, sel_load, scan_en, hold;
  logic [SW-1:0]   sel_in;
  logic [N*DW-1:0] data_in;
  logic [DW-1:0]   y;
  logic            y_valid;
  logic [SW-1:0]   cur_sel;
  logic            sel_err;

  always #5 clk = ~clk;

  scan_multiplexer #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (N),
    .SEL_WIDTH  (SW),
    .DWELL      (DWL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .sel_in   (sel_in),
    .sel_load (sel_load),
    .scan_en  (scan_en),
    .hold     (hold),
    .y        (y),
    .y_valid  (y_valid),
    .cur_sel  (cur_sel),
    .sel_err  (sel_err)
  );

  typedef struct {
    int y;
    int v;
    int sel;
    int err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ch [N];

  // Reference model: mode 0 = nothing selected, 1 = fixed channel, 2 = scanning.
  int m_mode = 0, m_sel = 0, m_dw = 0, m_y = 0, m_v = 0, m_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int ny, nv;
    if (rst) begin
      m_mode = 0; m_sel = 0; m_dw = 0; m_y = 0; m_v = 0; m_err = 0;
      return;
    end
    if (hold) begin
      m_err = 0;
      return;
    end
    ny = m_y;
    nv = m_v;
    if (m_mode != 0) begin
      ny = int'(ch[m_sel]);
      nv = 1;
    end
    m_err = 0;
    if (sel_load) begin
      if (int'(sel_in) < N) begin
        m_sel = int'(sel_in); m_dw = 0; m_mode = scan_en ? 2 : 1;
      end else begin
        m_err = 1;
      end
    end else if (scan_en && m_mode == 0) begin
      m_mode = 2; m_sel = 0; m_dw = 0;
    end else if (scan_en && m_mode == 1) begin
      m_mode = 2; m_dw = 0;
    end else if (!scan_en && m_mode == 2) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      m_dw = m_dw + 1;
      if (m_dw == DWL) begin
        m_dw  = 0;
        m_sel = (m_sel + 1) % N;
      end
    end
    m_y = ny;
    m_v = nv;
  endtask

  // Drives one cycle's inputs between edges and queues the expected result.
  task automatic cycle(input logic r, input logic h, input logic ld,
                       input logic [SW-1:0] si, input logic se);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r; hold = h; sel_load = ld; sel_in = si; scan_en = se;
    for (int k = 0; k < N; k++) data_in[k*DW +: DW] = ch[k];
    model_step();
    e.y = m_y; e.v = m_v; e.sel = m_sel; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("y", int'(y), e.y);
        chk("y_valid", int'(y_valid), e.v);
        chk("cur_sel", int'(cur_sel), e.sel);
        chk("sel_err", int'(sel_err), e.err);
      end
    end
  end

  initial begin : driver
    logic se_r;
    rst = 1'b1; hold = 1'b0; sel_load = 1'b0; sel_in = '0; scan_en = 1'b0;
    for (int k = 0; k < N; k++) ch[k] = DW'($urandom);
    for (int k = 0; k < N; k++) data_in[k*DW +: DW] = ch[k];

    // Reset with random data, then idle: outputs stay at reset values.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ch[i] = DW'($urandom);
      cycle(0, 0, 0, 0, 0);
    end
    after_edge();
    chk("idle_y_valid", int'(y_valid), 0);

    // Direct select of channel 5.
    ch[5] = 4'hA;
    cycle(0, 0, 1, 5, 0);
    after_edge();
    chk("direct_cur_sel", int'(cur_sel), 5);
    cycle(0, 0, 0, 0, 0);
    after_edge();
    chk("direct_y", int'(y), 10);
    chk("direct_y_valid", int'(y_valid), 1);
    ch[5] = 4'h3;
    cycle(0, 0, 0, 0, 0);
    after_edge();
    chk("direct_y_change", int'(y), 3);

    // Out-of-range load: one-cycle error, selection untouched.
    cycle(0, 0, 1, 12, 0);
    after_edge();
    chk("oor_err", int'(sel_err), 1);
    chk("oor_cur_sel", int'(cur_sel), 5);
    cycle(0, 0, 0, 0, 0);
    after_edge();
    chk("oor_err_drop", int'(sel_err), 0);

    // Scan from reset with channel k = k: each value held 3 cycles, wraps 9 -> 0.
    for (int k = 0; k < N; k++) ch[k] = DW'(k);
    cycle(1, 0, 0, 0, 1);
    for (int c = 1; c <= 35; c++) begin
      cycle(0, 0, 0, 0, 1);
      after_edge();
      if (c >= 2) chk("scan_seq", int'(y), ((c - 2) / DWL) % N);
    end

    // Hold in SCAN at channel 4 with one dwell cycle already spent.
    cycle(0, 0, 1, 4, 1);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, (i == 2), 7, 1);
    after_edge();
    chk("hold_cur_sel", int'(cur_sel), 4);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1);

    // Reset mid-scan at channel 6 with scan_en still high.
    cycle(0, 0, 1, 6, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    after_edge();
    chk("rst_mid_valid", int'(y_valid), 0);
    chk("rst_mid_sel", int'(cur_sel), 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1);

    // Randomized traffic.
    se_r = 1'b0;
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) ch[k] = DW'($urandom);
      if ($urandom_range(0, 14) == 0) se_r = ~se_r;
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0, SW'($urandom_range(0, 15)), se_r);
    end

    cycle(0, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
